// File: rtl/sliced_subtractor_seq_if.sv
// Operand/result handshake bundle for sliced_subtractor_seq.
// The master side presents operands and consumes the difference.
// The slave side is the subtractor itself.
interface sliced_subtractor_seq_if #(
    parameter int WIDTH = 4
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   diff;
    logic             busy;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  diff,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output diff,
        output busy
    );

endinterface

// File: rtl/sliced_subtractor_seq.sv
// Multi-cycle ripple-borrow subtractor.
// The block computes diff = a - b one SLICE-bit slice per clock, starting with the
// least significant slice. The borrow travels between slices in a register.
// The result is {final borrow, (a - b) mod 2^WIDTH}.
// WIDTH must be a multiple of SLICE.
// Optional feature, enabled by defining the macro SUB_SATURATE_EN: unsigned
// saturating subtract. When the final borrow is set, the whole result is
// forced to zero.
module sliced_subtractor_seq #(
    parameter int WIDTH = 4,
    parameter int SLICE = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    sliced_subtractor_seq_if.slave bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_next;
    logic [CNT_W-1:0] count;
    logic             borrow;
    logic [WIDTH:0]   diff_reg;
    logic [WIDTH:0]   diff_final;

    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_d;
    logic             slice_bout;

    logic             accept;
    logic             last_slice;
    logic             release_result;

    // Handshake qualifiers.
    // The block accepts operands only while idle.
    // The result is released only while DONE is presented.
    always_comb begin
        accept         = bus.in_valid && (state == IDLE);
        release_result = bus.out_ready && (state == DONE);
        last_slice     = (count == LAST_SLICE);
    end

    // One slice of the ripple-borrow subtraction.
    // The slice is computed one bit wider than SLICE so that the top bit of
    // the result is the outgoing borrow.
    always_comb begin
        slice_a = a_reg[int'(count) * SLICE +: SLICE];
        slice_b = b_reg[int'(count) * SLICE +: SLICE];
        {slice_bout, slice_d} = {1'b0, slice_a} - {1'b0, slice_b} - {{SLICE{1'b0}}, borrow};
        result_next = result_reg;
        result_next[int'(count) * SLICE +: SLICE] = slice_d;
    end

    // The value loaded into diff when the last slice completes.
    // With saturation enabled, a final borrow clamps the result to zero.
    always_comb begin
        diff_final = {slice_bout, result_next};
`ifdef SUB_SATURATE_EN
        if (slice_bout) begin
            diff_final = '0;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // BUSY runs for exactly NSLICE cycles.
    // DONE waits for the consumer to take the result.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_slice) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (release_result) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decodes, driven purely from the registered state.
    // No input reaches an output combinationally.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.busy      = (state == BUSY);
        bus.out_valid = (state == DONE);
        bus.diff      = diff_reg;
    end

    // Datapath: operand capture, slice-by-slice result build-up, borrow chain.
    // The visible diff changes only on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            count      <= '0;
            borrow     <= 1'b0;
            diff_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg      <= bus.a;
                        b_reg      <= bus.b;
                        result_reg <= '0;
                        count      <= '0;
                        borrow     <= 1'b0;
                    end
                end
                BUSY: begin
                    result_reg <= result_next;
                    borrow     <= slice_bout;
                    if (last_slice) begin
                        count    <= '0;
                        diff_reg <= diff_final;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sliced_subtractor_seq.sv
// Self-checking bench for sliced_subtractor_seq (WIDTH=4, SLICE=2).
// A transaction-level model predicts the handshake outputs and diff on every cycle.
// Directed operations check hand-computed results against literal expectations.
module tb_sliced_subtractor_seq;

    localparam int W      = 4;
    localparam int NSLICE = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    sliced_subtractor_seq_if #(.WIDTH(W)) bus ();

    sliced_subtractor_seq #(.WIDTH(W), .SLICE(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Compare one value and count the outcome.
    task checkOutput(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result: plain integer subtraction, wrapped to W+1 bits.
    function automatic logic [W:0] ref_sub(input int av, input int bv);
        int r;
        r = av - bv;
`ifdef SUB_SATURATE_EN
        if (r < 0) r = 0;
`endif
        return r[W:0];
    endfunction

    // Transaction model.
    // m_left counts the remaining compute cycles of an accepted operation.
    // m_done marks a result waiting for the consumer.
    int         m_left = 0;
    logic       m_done = 1'b0;
    logic [W:0] m_cap  = '0;
    logic [W:0] m_diff = '0;

    // Advance the model on every rising edge.
    // Then, 1 time unit later, compare all DUT outputs against it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_diff = '0;
        end else begin
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_diff = m_cap;
                end
            end else if (m_done) begin
                if (bus.out_ready) m_done = 1'b0;
            end else if (bus.in_valid) begin
                m_cap  = ref_sub(int'(bus.a), int'(bus.b));
                m_left = NSLICE;
            end
            #1;
            checkOutput("model_in_ready", int'(bus.in_ready), int'(m_left == 0 && !m_done));
            checkOutput("model_busy", int'(bus.busy), int'(m_left > 0));
            checkOutput("model_out_valid", int'(bus.out_valid), int'(m_done));
            checkOutput("model_diff", int'(bus.diff), int'(m_diff));
        end
    end

    // Wait for the block to be idle, present the operands for one accept edge,
    // then drop in_valid.
    task applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            checkOutput("accept_timeout", 0, 1);
        end
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Count the rising edges until out_valid appears, with a bounded wait.
    task waitDone(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        if (!bus.out_valid) begin
            checkOutput("done_timeout", 0, 1);
        end
    endtask

    // Take the result for one cycle, then confirm the return to idle.
    task consume();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("in_ready_after_take", int'(bus.in_ready), 1);
    endtask

    // Run one full operation and check its latency and result.
    task runOp(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
               input logic [W:0] exp);
        int cyc;
        applyStimulus(av, bv);
        waitDone(cyc);
        checkOutput({name, "_latency"}, cyc, NSLICE);
        checkOutput({name, "_diff"}, int'(bus.diff), int'(exp));
        consume();
    endtask

    // Watchdog.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;

        // Check the reset state while reset is held.
        #12;
        checkOutput("reset_in_ready", int'(bus.in_ready), 1);
        checkOutput("reset_out_valid", int'(bus.out_valid), 0);
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_diff", int'(bus.diff), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // A consumer ready signal while idle must be ignored.
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.out_ready = 1'b0;

        runOp("op_9_5", 4'd9, 4'd5, 5'b00100);
`ifdef SUB_SATURATE_EN
        runOp("op_5_9", 4'd5, 4'd9, 5'b00000);
        runOp("op_0_15", 4'd0, 4'd15, 5'b00000);
`else
        runOp("op_5_9", 4'd5, 4'd9, 5'b11100);
        runOp("op_0_15", 4'd0, 4'd15, 5'b10001);
`endif
        runOp("op_15_0", 4'd15, 4'd0, 5'b01111);
        runOp("op_7_7", 4'd7, 4'd7, 5'b00000);

        // Backpressure: the result must stay put while the consumer stalls.
        applyStimulus(4'd12, 4'd3);
        waitDone(cyc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", int'(bus.out_valid), 1);
            checkOutput("bp_diff", int'(bus.diff), 5'b01001);
            checkOutput("bp_in_ready", int'(bus.in_ready), 0);
        end
        consume();

        // Operand churn during BUSY must not disturb the captured operands.
        applyStimulus(4'd6, 4'd2);
        bus.in_valid = 1'b1;
        bus.a        = 4'd15;
        bus.b        = 4'd0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 4'd1;
        bus.b        = 4'd14;
        waitDone(cyc);
        checkOutput("churn_diff", int'(bus.diff), 5'b00100);
        consume();
        @(negedge clk);
        checkOutput("churn_no_second_accept", int'(bus.busy), 0);

        // Abort: reset one cycle after accept.
        applyStimulus(4'd10, 4'd3);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", int'(bus.out_valid), 0);
        checkOutput("abort_diff", int'(bus.diff), 0);
        checkOutput("abort_in_ready", int'(bus.in_ready), 1);
        checkOutput("abort_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        runOp("op_3_1", 4'd3, 4'd1, 5'b00010);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sliced_subtractor_seq.md
Name: sliced_subtractor_seq

Overview:
- Multi-cycle ripple-borrow subtractor: computes diff = a - b one SLICE-bit slice per clock, LSB slice first, with the borrow carried between cycles in a register.
- Result format mirrors the sliced adder's: WIDTH difference bits plus one extra MSB holding the borrow, so the full result is the WIDTH+1-bit two's-complement value of a - b.
- Sits in the regression arithmetic set as the inverse-operation counterpart of the sliced adders.
- Exercises flattening of a stateful, handshaked datapath.

Parameters:
- WIDTH, 4, operand width in bits; must be a multiple of SLICE.
- SLICE, 2, bits processed per clock; NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  diff valid.
- out_ready  input  1  consumer takes diff.
- diff  output  WIDTH+1  {borrow, (a-b) mod 2^WIDTH}.
- busy  output  1  subtraction in progress.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; slice counter=0; borrow register=0; operand and result registers=0; diff=0; out_valid=0; busy=0; in_ready=1 (it decodes from IDLE).
- FSM states IDLE, BUSY, DONE.
- in_ready = (state==IDLE); busy = (state==BUSY); out_valid = (state==DONE). All are registered-state decodes; there is no combinational path from inputs to outputs.
- IDLE: on in_valid && in_ready:
  - capture a and b;
  - clear borrow and slice counter;
  - go to BUSY.
- BUSY, each cycle, with k = counter:
  - {bout, d} = a[k-slice] - b[k-slice] - borrow, computed at SLICE+1 bits;
  - d is written to result slice k, and borrow <= bout;
  - counter increments.
- BUSY exit: after the edge processing slice NSLICE-1:
  - diff[WIDTH] <= final borrow;
  - go to DONE;
  - counter wraps to 0.
- Latency: out_valid rises exactly NSLICE clocks after the accept edge (2 for the defaults).
- DONE:
  - diff and out_valid hold stable until out_ready=1;
  - on out_valid && out_ready, go to IDLE.
  - A new operand cannot be accepted in the same cycle (in_ready=0 in DONE). Peak throughput is one op per NSLICE+2 cycles.
- in_valid during BUSY/DONE is ignored. a and b may change freely after the accept edge without affecting the result.
- diff holds its last value in IDLE and BUSY. It is updated only on entry to DONE; the partial result is kept in an internal register.
- Equal operands give diff=0 and borrow=0. Any a<b sets diff[WIDTH]=1.
- Reset asserted mid-operation aborts immediately: all state returns to reset values and no out_valid is produced.
- out_ready high outside DONE has no effect.

Optional Feature:
- Macro SUB_SATURATE_EN.
- Defined: on entry to DONE, if the final borrow is 1, diff is forced to all zeros (including the MSB), i.e. unsigned saturating subtract. Timing and handshake are unchanged.
- Undefined: diff is the raw {borrow, difference} value.

Test Plan:
- After reset: a=9, b=5, in_valid pulse -> out_valid exactly 2 cycles after accept, diff=5'b00100.
- a=5, b=9 -> diff=5'b11100 (-4). With SUB_SATURATE_EN: a=5, b=9 -> diff=5'b00000.
- Extremes: a=15, b=0 -> diff=5'b01111; a=0, b=15 -> diff=5'b10001; a=b=7 -> diff=0.
- Backpressure: hold out_ready=0 for 5 cycles after a=12, b=3 -> diff=5'b01001 stable and out_valid=1 throughout. in_ready stays 0 until the cycle after out_ready=1.
- Operand churn: change a/b and toggle in_valid during BUSY -> result still reflects the captured operands; no second accept occurs.
- Abort: assert rst_n=0 one cycle after accept -> out_valid=0, diff=0, in_ready=1 immediately. The next op (a=3, b=1 -> 5'b00010) completes normally.
